icache_ctrl: RTL

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_array.sv | 55 +++++
 rtl/icache_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared geometry, address slicing widths and FSM state encoding for the
// direct-mapped instruction cache controller.
package icache_pkg;

  localparam int ICACHE_INDEX_BITS = 4;
  localparam int INDEX_BITS = ICACHE_INDEX_BITS;
  localparam int LINES      = 1 << INDEX_BITS;
  localparam int WORDS      = 4;
  localparam int BASE_BITS  = 28;
  localparam int TAG_BITS   = 32 - 4 - INDEX_BITS;

  typedef enum logic [1:0] {
    IC_IDLE   = 2'd0,
    IC_REFILL = 2'd1,
    IC_DRAIN  = 2'd2
  } ic_state_e;

  typedef logic [INDEX_BITS-1:0] index_t;
  typedef logic [TAG_BITS-1:0]   tag_t;
  typedef logic [BASE_BITS-1:0]  base_t;

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage with one write port and one registered read port.
// The read port returns the selected word and a registered tag-match hit flag.
module icache_array
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rd_en,
  input  index_t      rd_index,
  input  logic [1:0]  rd_word,
  input  tag_t        rd_tag,
  output logic        rd_hit,
  output logic [31:0] rd_data,
  input  logic        wr_data_en,
  input  logic        wr_line_en,
  input  index_t      wr_index,
  input  logic [1:0]  wr_word,
  input  logic [31:0] wr_data,
  input  tag_t        wr_tag,
  input  logic        wr_valid
);

  tag_t             tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][WORDS];
  logic [LINES-1:0] valid;

  // Only the valid bits are reset; tags and data are don't-care until validated.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (rdy && wr_line_en) begin
      valid[wr_index] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (wr_line_en) tag_mem[wr_index] <= wr_tag;
      if (wr_data_en) data_mem[wr_index][wr_word] <= wr_data;
    end
  end

  // The hit flag is cleared on every enabled cycle without a read, so it pulses once per lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_hit  <= 1'b0;
      rd_data <= '0;
    end else if (rdy) begin
      rd_hit <= rd_en && valid[rd_index] && (tag_mem[rd_index] == rd_tag);
      if (rd_en) rd_data <= data_mem[rd_index][rd_word];
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: 1-cycle hits, in-order 4-word
// line refill from the memory controller, flush handling via a DRAIN state.
module icache_ctrl
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  input  logic        flush,
  output logic        hit_valid,
  output logic [31:0] inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);

  ic_state_e  state;
  logic [1:0] counter;
  base_t      base;
  logic       pending;
  logic       lookup;
  logic       wr_data_en;
  logic       wr_line_en;
  logic       wr_valid;
  logic       unused_offset;

  assign unused_offset = ^fetch_addr[1:0];

  // A lookup is refused in its own result cycle so a held request cannot produce a second hit.
  assign lookup = (state == IC_IDLE) && fetch_valid && !flush && !pending;

  always_comb begin
    wr_data_en = 1'b0;
    wr_line_en = 1'b0;
    wr_valid   = 1'b0;
    if (state == IC_IDLE) begin
      if (pending && !hit_valid && !flush) wr_line_en = 1'b1;
    end else if (state == IC_REFILL && mem_req && mem_done) begin
      wr_data_en = 1'b1;
      if (counter == 2'd3) begin
        wr_line_en = 1'b1;
        wr_valid   = 1'b1;
      end
    end
  end

  icache_array u_array (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .rd_en      (lookup),
    .rd_index   (fetch_addr[3+INDEX_BITS:4]),
    .rd_word    (fetch_addr[3:2]),
    .rd_tag     (fetch_addr[31:4+INDEX_BITS]),
    .rd_hit     (hit_valid),
    .rd_data    (inst),
    .wr_data_en (wr_data_en),
    .wr_line_en (wr_line_en),
    .wr_index   (base[INDEX_BITS-1:0]),
    .wr_word    (counter),
    .wr_data    (mem_data),
    .wr_tag     (base[BASE_BITS-1:INDEX_BITS]),
    .wr_valid   (wr_valid)
  );

  // mem_req drops for one cycle after every completion; the gap cycle re-issues the next word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IC_IDLE;
      counter  <= 2'd0;
      base     <= '0;
      pending  <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else if (rdy) begin
      pending <= lookup;
      case (state)
        IC_IDLE: begin
          if (lookup) base <= fetch_addr[31:4];
          if (pending && !hit_valid && !flush) begin
            state    <= IC_REFILL;
            counter  <= 2'd0;
            mem_req  <= 1'b1;
            mem_addr <= {base, 4'b0000};
          end
        end
        IC_REFILL: begin
          if (mem_req) begin
            if (mem_done) begin
              mem_req <= 1'b0;
              counter <= counter + 2'd1;
              if (flush || counter == 2'd3) state <= IC_IDLE;
            end else if (flush) begin
              state <= IC_DRAIN;
            end
          end else if (flush) begin
            state <= IC_IDLE;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= {base, counter, 2'b00};
          end
        end
        IC_DRAIN: begin
          if (mem_done) begin
            mem_req <= 1'b0;
            state   <= IC_IDLE;
          end
        end
        default: state <= IC_IDLE;
      endcase
    end
  end

endmodule
